// File: rtl/sram_mem_ctrl.sv
// Memory-stage controller: splits 32-bit LDR/STR accesses into two 16-bit SRAM half-word cycles.
// Optional one-entry last-read buffer is enabled by defining SRAM_LAST_READ_CACHE_EN.
module sram_mem_ctrl #(
    parameter int unsigned ADDR_BASE   = 1024,
    parameter int unsigned WAIT_CYCLES = 5,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_wdata,
    input  logic [15:0]        sram_rdata,
    output logic               sram_we_n
);

    localparam int unsigned WW = SRAM_AW - 1;

    if (WAIT_CYCLES < 3 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("sram_mem_ctrl: WAIT_CYCLES must be in 3..15");
    end

    typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_WAIT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic          is_wr_q, is_wr_d;
    logic [WW-1:0] word_q, word_d;
    logic [31:0]   wd_q, wd_d;
    logic [15:0]   lo_buf_q, lo_buf_d;
    logic [31:0]   read_data_q, read_data_d;
    logic [3:0]    cnt_q, cnt_d;

    logic [31:0]   off;
    logic [WW-1:0] word_in;
    logic          req;
    logic          hit;
    logic          unused_off;

    assign off        = address - 32'(ADDR_BASE);
    assign word_in    = off[SRAM_AW:2];
    assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};
    assign req        = rd_en | wr_en;
    assign read_data  = read_data_q;

`ifdef SRAM_LAST_READ_CACHE_EN
    logic          c_vld_q, c_vld_d;
    logic [WW-1:0] c_tag_q, c_tag_d;
    logic [31:0]   c_data_q, c_data_d;

    // A simultaneous write wins, so only a pure read may hit.
    assign hit = rd_en && !wr_en && c_vld_q && (c_tag_q == word_in);
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        word_d      = word_q;
        wd_d        = wd_q;
        lo_buf_d    = lo_buf_q;
        read_data_d = read_data_q;
        cnt_d       = cnt_q;
`ifdef SRAM_LAST_READ_CACHE_EN
        c_vld_d     = c_vld_q;
        c_tag_d     = c_tag_q;
        c_data_d    = c_data_q;
`endif
        ready       = 1'b0;
        sram_we_n   = 1'b1;
        sram_addr   = '0;
        sram_wdata  = '0;

        case (state_q)
            S_IDLE: begin
                ready = !req;
                if (hit) begin
                    ready = 1'b1;
`ifdef SRAM_LAST_READ_CACHE_EN
                    read_data_d = c_data_q;
`endif
                end else if (req) begin
                    state_d = S_LO;
                    is_wr_d = wr_en;
                    word_d  = word_in;
                    wd_d    = write_data;
                end
            end
            S_LO: begin
                sram_addr = {word_q, 1'b0};
                if (is_wr_q) begin
                    sram_we_n  = 1'b0;
                    sram_wdata = wd_q[15:0];
                end else begin
                    lo_buf_d = sram_rdata;
                end
                state_d = S_HI;
            end
            S_HI: begin
                sram_addr = {word_q, 1'b1};
                if (is_wr_q) begin
                    sram_we_n  = 1'b0;
                    sram_wdata = wd_q[31:16];
`ifdef SRAM_LAST_READ_CACHE_EN
                    // Write-through keeps the buffered word coherent.
                    if (c_vld_q && c_tag_q == word_q) c_data_d = wd_q;
`endif
                end else begin
                    read_data_d = {sram_rdata, lo_buf_q};
`ifdef SRAM_LAST_READ_CACHE_EN
                    c_vld_d  = 1'b1;
                    c_tag_d  = word_q;
                    c_data_d = {sram_rdata, lo_buf_q};
`endif
                end
                cnt_d   = 4'(WAIT_CYCLES - 3);
                state_d = (WAIT_CYCLES == 3) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                ready   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            is_wr_q     <= 1'b0;
            word_q      <= '0;
            wd_q        <= '0;
            lo_buf_q    <= '0;
            read_data_q <= '0;
            cnt_q       <= '0;
`ifdef SRAM_LAST_READ_CACHE_EN
            c_vld_q     <= 1'b0;
            c_tag_q     <= '0;
            c_data_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            word_q      <= word_d;
            wd_q        <= wd_d;
            lo_buf_q    <= lo_buf_d;
            read_data_q <= read_data_d;
            cnt_q       <= cnt_d;
`ifdef SRAM_LAST_READ_CACHE_EN
            c_vld_q     <= c_vld_d;
            c_tag_q     <= c_tag_d;
            c_data_q    <= c_data_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
module tb_sram_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata, sram_rdata;
  logic        sram_we_n;

  always #5 clk = ~clk;

  sram_mem_ctrl dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_we_n(sram_we_n)
  );

  logic [15:0] mem [0:262143];
  assign sram_rdata = mem[sram_addr];
  always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_wdata;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic        rec_we   [32];
  logic [17:0] rec_addr [32];
  logic [15:0] rec_wd   [32];
  int          n;
  logic [11:0] pat;
  logic [11:0] pat_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, output int cyc);
    logic [31:0] e;
    @(posedge clk); #1;
    wr_en = w; rd_en = r; address = a; write_data = d;
    if (r && !w) exp_q.push_back(exp_rd);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (ready) break;
      rec_we[cyc]   = sram_we_n;
      rec_addr[cyc] = sram_addr;
      rec_wd[cyc]   = sram_wdata;
      cyc++;
      if (cyc >= 31) break;
    end
    chk("no_timeout", 32'(cyc < 31), 32'd1);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    if (r && !w) begin
      e = exp_q.pop_front();
      chk("read_data", read_data, e);
    end
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_we_n", sram_we_n, 1'b1);
    chk("rst_addr", sram_addr, 18'h0);
    chk("rst_wdata", sram_wdata, 16'h0);
    chk("rst_rdata", read_data, 32'h0);

    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h0, n);
    chk("w_cycles", n, 5);
    chk("w_we0", rec_we[0], 1'b1);
    chk("w_we1", rec_we[1], 1'b0);
    chk("w_we2", rec_we[2], 1'b0);
    chk("w_we3", rec_we[3], 1'b1);
    chk("w_we4", rec_we[4], 1'b1);
    chk("w_addr1", rec_addr[1], 18'h0);
    chk("w_addr2", rec_addr[2], 18'h1);
    chk("w_wd1", rec_wd[1], 16'hBEEF);
    chk("w_wd2", rec_wd[2], 16'hDEAD);

    access(1'b0, 1'b1, 32'd1024, 32'h0, 32'hDEADBEEF, n);
    chk("r_cycles", n, 5);
    chk("r_we1", rec_we[1], 1'b1);
    chk("r_we2", rec_we[2], 1'b1);

    access(1'b1, 1'b0, 32'd1032, 32'h11112222, 32'h0, n);
    chk("t1032_addr1", rec_addr[1], 18'h4);
    chk("t1032_addr2", rec_addr[2], 18'h5);
    access(1'b0, 1'b1, 32'd1035, 32'h0, 32'h11112222, n);
    chk("t1035_addr1", rec_addr[1], 18'h4);
    chk("t1035_addr2", rec_addr[2], 18'h5);

    access(1'b1, 1'b0, 32'd1020, 32'h33334444, 32'h0, n);
    chk("t1020_addr1", rec_addr[1], 18'h3FFFE);
    chk("t1020_addr2", rec_addr[2], 18'h3FFFF);
    chk("t1020_wd1", rec_wd[1], 16'h4444);
    chk("t1020_mem", mem[18'h3FFFF], 16'h3333);

    @(posedge clk); #1;
    rd_en = 1'b1; address = 32'd2048;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pat[i] = ready;
    end
    @(posedge clk); #1;
    rd_en = 1'b0;
`ifdef SRAM_LAST_READ_CACHE_EN
    pat_exp = 12'b1111_1110_0000;
`else
    pat_exp = 12'b1000_0010_0000;
`endif
    chk("b2b_pattern", pat, pat_exp);
    chk("b2b_data", read_data, 32'h0);

    access(1'b0, 1'b1, 32'd1024, 32'h0, 32'hDEADBEEF, n);
    access(1'b1, 1'b1, 32'd1040, 32'h12345678, 32'h0, n);
    chk("both_cycles", n, 5);
    chk("both_we1", rec_we[1], 1'b0);
    chk("both_rdata", read_data, 32'hDEADBEEF);
    chk("both_mem_lo", mem[8], 16'h5678);
    chk("both_mem_hi", mem[9], 16'h1234);

    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'd1024; write_data = 32'h55556666;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("mid_hi_we", sram_we_n, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    chk("mid_ready", ready, 1'b1);
    chk("mid_we_n", sram_we_n, 1'b1);
    chk("mid_addr", sram_addr, 18'h0);
    chk("mid_rdata", read_data, 32'h0);
    chk("mid_mem_lo", mem[0], 16'h6666);

    access(1'b0, 1'b1, 32'd1024, 32'h0, 32'h55556666, n);
    chk("post_rst_cycles", n, 5);

`ifdef SRAM_LAST_READ_CACHE_EN
    access(1'b0, 1'b1, 32'd1024, 32'h0, 32'h55556666, n);
    chk("hit_cycles", n, 0);
    chk("hit_we_n", sram_we_n, 1'b1);
    access(1'b1, 1'b0, 32'd1024, 32'hCAFEF00D, 32'h0, n);
    chk("wt_cycles", n, 5);
    access(1'b0, 1'b1, 32'd1024, 32'h0, 32'hCAFEF00D, n);
    chk("wt_hit_cycles", n, 0);
`endif

    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
